// File: rtl/serial_operand_feeder.sv
// serial_operand_feeder: buffers parallel operand pairs in a small FIFO and
// serialises each pair LSB-first as two aligned bit streams with first/last
// frame markers. Frames go out back-to-back while operands are queued.
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   in_valid/in_ready      parallel operand handshake (in_a, in_b)
//   ser_en                 downstream consumes the current bit this cycle
//   bit_valid, a_bit,      current serial bits and frame markers
//   b_bit, first, last
//   busy                   frame in progress or FIFO non-empty
//   level                  FIFO occupancy, 0..DEPTH
module serial_operand_feeder #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic                     ser_en,
    output logic                     bit_valid,
    output logic                     a_bit,
    output logic                     b_bit,
    output logic                     first,
    output logic                     last,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [CW-1:0]    cnt_q;
    logic             first_q;
    logic             last_q;

    logic [WIDTH-1:0] mem_a_q [DEPTH];
    logic [WIDTH-1:0] mem_b_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;

    logic             push;
    logic             pop;

    // Acceptance depends on occupancy only; a same-cycle pop does not free a slot.
    assign in_ready = rst && (level_q < LW'(DEPTH));
    assign push     = in_valid && in_ready;
    // A pop is always a load: from IDLE, or chained on the consumed last bit.
    assign pop      = (level_q != '0) && ((state_q == IDLE) || (ser_en && last_q));

    // FIFO storage, no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= in_a;
            mem_b_q[wr_ptr_q] <= in_b;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + LW'(push) - LW'(pop);
        end
    end

    // Serialiser FSM: load on pop, shift on ser_en, drop to IDLE after an unchained last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (pop) begin
            state_q <= SHIFT;
            sa_q    <= mem_a_q[rd_ptr_q];
            sb_q    <= mem_b_q[rd_ptr_q];
            cnt_q   <= '0;
            first_q <= 1'b1;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= IDLE;
                end
                SHIFT: begin
                    if (ser_en) begin
                        if (!last_q) begin
                            sa_q    <= sa_q >> 1;
                            sb_q    <= sb_q >> 1;
                            cnt_q   <= cnt_q + CW'(1);
                            first_q <= 1'b0;
                            last_q  <= (cnt_q == CW'(WIDTH - 2));
                        end else begin
                            // Clear the shifters so IDLE drives zero bits.
                            state_q <= IDLE;
                            sa_q    <= '0;
                            sb_q    <= '0;
                            cnt_q   <= '0;
                            first_q <= 1'b0;
                            last_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bit_valid = (state_q == SHIFT);
    assign a_bit     = sa_q[0];
    assign b_bit     = sb_q[0];
    assign first     = first_q;
    assign last      = last_q;
    assign busy      = (state_q == SHIFT) || (level_q != '0);
    assign level     = level_q;

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Self-checking bench for serial_operand_feeder: directed vector table,
// hand-written corner sequences and randomized traffic against a frame-level
// reference model (queue of pairs plus current frame and bit index).
module tb_serial_operand_feeder;

    localparam int unsigned W  = 4;
    localparam int unsigned D  = 2;
    localparam int unsigned LW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          ser_en;
    logic          bit_valid;
    logic          a_bit;
    logic          b_bit;
    logic          first;
    logic          last;
    logic          busy;
    logic [LW-1:0] level;

    serial_operand_feeder #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .ser_en    (ser_en),
        .bit_valid (bit_valid),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .first     (first),
        .last      (last),
        .busy      (busy),
        .level     (level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queued pairs, the frame being sent and its bit index.
    logic [2*W-1:0] mq[$];
    logic [W-1:0]   cur_a;
    logic [W-1:0]   cur_b;
    int             idx;
    bit             active;

    logic s_bv, s_a, s_b, s_first, s_last, s_busy, s_rdy;
    logic [LW-1:0] s_level;

    typedef struct {
        logic          iv;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          se;
        logic          bv;
        logic          ab;
        logic          bb;
        logic          fi;
        logic          la;
        logic          bs;
        logic          rdy;
        logic [LW-1:0] lvl;
    } vec_t;

    vec_t vt[7];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void model_edge();
        bit push;
        bit ld;
        push = in_valid && (mq.size() < D);
        ld   = (mq.size() > 0) && (!active || (ser_en && idx == W - 1));
        if (active && ser_en) begin
            if (idx < W - 1) idx++;
            else active = 0;
        end
        if (ld) begin
            {cur_a, cur_b} = mq.pop_front();
            idx    = 0;
            active = 1;
        end
        if (push) mq.push_back({in_a, in_b});
    endfunction

    // One clock: compare at negedge against the model, then advance it at posedge.
    task automatic step();
        @(negedge clk);
        if (!rst) begin
            mq.delete();
            active = 0;
            idx    = 0;
        end
        s_bv = bit_valid; s_a = a_bit; s_b = b_bit; s_first = first;
        s_last = last; s_busy = busy; s_rdy = in_ready; s_level = level;
        chk("m_in_ready",  32'(in_ready),  32'(rst && (mq.size() < D)));
        chk("m_bit_valid", 32'(bit_valid), 32'(active));
        chk("m_a_bit",     32'(a_bit),     32'(active ? cur_a[idx] : 1'b0));
        chk("m_b_bit",     32'(b_bit),     32'(active ? cur_b[idx] : 1'b0));
        chk("m_first",     32'(first),     32'(active && idx == 0));
        chk("m_last",      32'(last),      32'(active && idx == W - 1));
        chk("m_busy",      32'(busy),      32'(active || mq.size() > 0));
        chk("m_level",     32'(level),     32'(mq.size()));
        @(posedge clk);
        if (rst) model_edge();
        #1;
    endtask

    int run;
    bit ended;
    int nb;

    initial begin
        rst = 1'b0; in_valid = 1'b1; ser_en = 1'b0; in_a = '0; in_b = '0;
        active = 0; idx = 0; cur_a = '0; cur_b = '0;

        vt[0] = '{1'b1, 4'h2, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
        vt[1] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1};
        vt[2] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0};
        vt[3] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
        vt[4] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
        vt[5] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0};
        vt[6] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};

        repeat (2) @(posedge clk);
        #1;

        // Reset held with in_valid high.
        step();
        chk("rst_in_ready", 32'(s_rdy), 32'(0));
        chk("rst_bit_valid", 32'(s_bv), 32'(0));
        chk("rst_level", 32'(s_level), 32'(0));
        rst = 1'b1; in_valid = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'(1));
        step();

        // Single frame A=0010, B=1000.
        for (int i = 0; i < 7; i++) begin
            in_valid = vt[i].iv; in_a = vt[i].a; in_b = vt[i].b; ser_en = vt[i].se;
            step();
            chk($sformatf("vec%0d_bit_valid", i), 32'(s_bv),    32'(vt[i].bv));
            chk($sformatf("vec%0d_a_bit", i),     32'(s_a),     32'(vt[i].ab));
            chk($sformatf("vec%0d_b_bit", i),     32'(s_b),     32'(vt[i].bb));
            chk($sformatf("vec%0d_first", i),     32'(s_first), 32'(vt[i].fi));
            chk($sformatf("vec%0d_last", i),      32'(s_last),  32'(vt[i].la));
            chk($sformatf("vec%0d_busy", i),      32'(s_busy),  32'(vt[i].bs));
            chk($sformatf("vec%0d_in_ready", i),  32'(s_rdy),   32'(vt[i].rdy));
            chk($sformatf("vec%0d_level", i),     32'(s_level), 32'(vt[i].lvl));
        end

        // Fill while stalled, then back-to-back frames.
        ser_en = 1'b0; in_valid = 1'b1;
        in_a = 4'h3; in_b = 4'h5; step();
        in_a = 4'hC; in_b = 4'h9; step();
        in_a = 4'h7; in_b = 4'hE; step();
        chk("full_level", 32'(level), 32'(2));
        chk("full_in_ready", 32'(in_ready), 32'(0));
        in_a = 4'hF; in_b = 4'hF; step();
        chk("refused_level", 32'(level), 32'(2));
        in_valid = 1'b0; ser_en = 1'b1;
        run = 0; ended = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_bv) begin
                if (!ended) run++;
            end else if (run > 0) begin
                ended = 1;
            end
        end
        chk("b2b_run_length", 32'(run), 32'(12));

        // Stall at cnt=1.
        in_valid = 1'b1; in_a = 4'b1011; in_b = 4'b0110; ser_en = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        nb = 1;
        ser_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_first", 32'(s_first), 32'(0));
            chk("stall_last",  32'(s_last),  32'(0));
            chk("stall_a_bit", 32'(s_a),     32'(1));
            chk("stall_b_bit", 32'(s_b),     32'(1));
        end
        ser_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (s_bv) nb++;
            if (s_last) break;
        end
        chk("stall_frame_bits", 32'(nb), 32'(4));

        // Full FIFO with last consumed and in_valid high.
        ser_en = 1'b0; in_valid = 1'b1;
        in_a = 4'h1; in_b = 4'h2; step();
        in_a = 4'h4; in_b = 4'h8; step();
        in_a = 4'hA; in_b = 4'h6; step();
        ser_en = 1'b1; in_a = 4'hD; in_b = 4'hB;
        repeat (4) step();
        chk("pop_refuse_level", 32'(level), 32'(1));
        chk("pop_refuse_ready", 32'(in_ready), 32'(1));
        in_valid = 1'b0;
        repeat (12) step();

        // Reset mid-frame at cnt=2 with one pair queued.
        in_valid = 1'b1; in_a = 4'h9; in_b = 4'h6; step();
        in_a = 4'h3; in_b = 4'hC; step();
        in_valid = 1'b0; ser_en = 1'b1;
        step();
        step();
        chk("pre_rst_level", 32'(level), 32'(1));
        rst = 1'b0;
        #1;
        chk("midrst_bit_valid", 32'(bit_valid), 32'(0));
        chk("midrst_level",     32'(level),     32'(0));
        chk("midrst_in_ready",  32'(in_ready),  32'(0));
        chk("midrst_last",      32'(last),      32'(0));
        chk("midrst_busy",      32'(busy),      32'(0));
        step();
        rst = 1'b1; in_valid = 1'b1; in_a = 4'b0101; in_b = 4'b0011;
        step();
        in_valid = 1'b0;
        step();
        chk("restart_first", 32'(first), 32'(1));
        chk("restart_a_bit", 32'(a_bit), 32'(1));
        chk("restart_b_bit", 32'(b_bit), 32'(1));
        repeat (6) step();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            rst      = ($urandom_range(0, 59) != 0);
            in_valid = 1'($urandom_range(0, 1));
            ser_en   = ($urandom_range(0, 3) != 0);
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            step();
        end

        rst = 1'b1; in_valid = 1'b0; ser_en = 1'b1;
        repeat (20) step();
        chk("drain_busy", 32'(busy), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
